// File: rtl/axis_beam_sync_if.sv
// AXI-Stream handshake bundle between the beam sync controller, its upstream
// per-stream sources and the downstream summed output.
interface axis_beam_sync_if #(
  parameter int unsigned NUM_STREAMS = 8
);

  logic [NUM_STREAMS-1:0] s_tvalid;
  logic [NUM_STREAMS-1:0] s_tlast;
  logic [NUM_STREAMS-1:0] s_tready;
  logic                   m_tready;

  // Stimulus / upstream side
  modport master (
    output s_tvalid,
    output s_tlast,
    output m_tready,
    input  s_tready
  );

  // Controller side
  modport slave (
    input  s_tvalid,
    input  s_tlast,
    input  m_tready,
    output s_tready
  );

endinterface

// File: rtl/axis_beam_sync_ctrl.sv
// Beam-sum sequencer: aligns NUM_STREAMS AXI-Stream inputs, consumes them in
// lockstep while the adder sums, drains after a tlast misalignment and falls
// back to channel00 bypass when alignment times out.
// Optional macro BEAM_SYNC_STATS_EN adds the completed-frame counter frame_cnt.
module axis_beam_sync_ctrl #(
  parameter int unsigned NUM_STREAMS = 8,
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 clear_err,
  axis_beam_sync_if.slave      bus,
  output logic                 sum_en,
  output logic                 bypass,
  output logic [2:0]           state,
  output logic [15:0]          beat_cnt,
  output logic                 misalign_err,
  output logic [31:0]          frame_cnt
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0]       LAST_BEAT = 16'(FRAME_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    SUM    = 3'd2,
    DRAIN  = 3'd3,
    BYPASS = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [15:0]            beat_cnt_q, beat_cnt_d;
  logic [NUM_STREAMS-1:0] drain_mask_q, drain_mask_d;
  logic                   misalign_q, misalign_d;
  logic                   bypass_q, bypass_d;

  logic                   all_valid_c;
  logic                   all_last_c;
  logic                   any_last_c;
  logic                   at_last_beat_c;
  logic                   misalign_now_c;
  logic [NUM_STREAMS-1:0] s_tready_c;
  logic [NUM_STREAMS-1:0] drain_next_c;

  assign all_valid_c    = &bus.s_tvalid;
  assign all_last_c     = &bus.s_tlast;
  assign any_last_c     = |bus.s_tlast;
  assign at_last_beat_c = (beat_cnt_q == LAST_BEAT);

  // Summed-beat handshake; gated by reset so nothing is consumed while held in reset
  assign sum_en = resetn & (state_q == SUM) & bus.m_tready & all_valid_c;

  // Partial tlast, or a full tlast before the final beat, breaks frame alignment
  assign misalign_now_c = sum_en &
                          ((any_last_c & ~all_last_c) | (all_last_c & ~at_last_beat_c));

  // Streams whose tlast has been seen, including any accepted this cycle
  assign drain_next_c = drain_mask_q | (s_tready_c & bus.s_tvalid & bus.s_tlast);

  // Per-stream tready: lockstep in SUM, per-stream in DRAIN, follow downstream in BYPASS
  always_comb begin
    s_tready_c = '0;
    if (resetn) begin
      unique case (state_q)
        SUM:     s_tready_c = {NUM_STREAMS{bus.m_tready & all_valid_c}};
        DRAIN:   s_tready_c = ~drain_mask_q;
        BYPASS:  s_tready_c = {NUM_STREAMS{bus.m_tready}};
        default: s_tready_c = '0;
      endcase
    end
  end

  assign bus.s_tready = s_tready_c;

  // Next-state, counters, drain mask and sticky error
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    beat_cnt_d   = beat_cnt_q;
    drain_mask_d = drain_mask_q;
    misalign_d   = clear_err ? 1'b0 : misalign_q;

    unique case (state_q)
      IDLE: begin
        wait_d       = '0;
        beat_cnt_d   = '0;
        drain_mask_d = '0;
        if (enable) begin
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        if (!enable) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (all_valid_c) begin
          state_d    = SUM;
          beat_cnt_d = '0;
          wait_d     = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = BYPASS;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      SUM: begin
        if (sum_en) begin
          beat_cnt_d = at_last_beat_c ? 16'd0 : beat_cnt_q + 16'd1;
          if (misalign_now_c) begin
            state_d      = DRAIN;
            drain_mask_d = bus.s_tlast;
          end else if (at_last_beat_c && !enable) begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        drain_mask_d = drain_next_c;
        if (&drain_next_c) begin
          state_d      = ALIGN;
          drain_mask_d = '0;
          wait_d       = '0;
        end
      end

      BYPASS: begin
        wait_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (bus.m_tready && all_valid_c && all_last_c) begin
          state_d = ALIGN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new error wins over a simultaneous clear
    if (misalign_now_c) begin
      misalign_d = 1'b1;
    end
  end

  assign bypass_d = (state_d == BYPASS);

  // State and status registers, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      beat_cnt_q   <= '0;
      drain_mask_q <= '0;
      misalign_q   <= 1'b0;
      bypass_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      beat_cnt_q   <= beat_cnt_d;
      drain_mask_q <= drain_mask_d;
      misalign_q   <= misalign_d;
      bypass_q     <= bypass_d;
    end
  end

  assign state        = state_q;
  assign beat_cnt     = beat_cnt_q;
  assign misalign_err = misalign_q;
  assign bypass       = bypass_q;

`ifdef BEAM_SYNC_STATS_EN
  logic        frame_end_c;
  logic [31:0] frame_cnt_q, frame_cnt_d;

  assign frame_end_c = sum_en & at_last_beat_c & ~misalign_now_c;

  // Completed summed frames, free-running wrap at 2^32
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_end_c) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  // Frame counter register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
